demux_rr_sched: RTL and testbench
=================================

// Module: demux_rr_sched
// PURPOSE
//   Round-robin scheduler for the 1-to-4 demultiplexer (enable, sel[1:0] -> A/B/C/D).
//   Four requesters share the demux output lanes. Each granted requester receives a
//   timed enable burst of HOLD_CYCLES on its lane, followed by a GAP_CYCLES guard
//   interval. The block sits directly in front of the demux and drives its enable and sel.
// PARAMETERS
//   HOLD_CYCLES  4  cycles enable is held high per grant; legal range >= 1
//   GAP_CYCLES   1  guard cycles with enable low and sel held; legal range >= 0 (0 = no GAP state)
// PORTS
//   clk     in   1  single clock; all state updates on its rising edge
//   reset   in   1  asynchronous, active-high reset
//   req     in   4  request per lane; bit i = lane i (0=A 1=B 2=C 3=D); level-sensitive
//   sel     out  2  demux select; registered
//   enable  out  1  demux enable; registered
//   grant   out  4  one-hot lane currently served (ACTIVE or GAP); registered
//   busy    out  1  high in ACTIVE or GAP
//   done    out  1  one-cycle pulse after a service completes
// BEHAVIOUR
//   Reset (async): state=IDLE, sel=0, enable=0, grant=0, busy=0, done=0, cnt=0,
//     last=3, so lane 0 has top priority after reset. Deassertion takes effect at the next edge.
//   FSM states: IDLE -> ACTIVE -> GAP -> IDLE. If GAP_CYCLES=0, ACTIVE -> IDLE directly.
//   IDLE: at each edge, if req!=0, pick the first set bit searching last+1, last+2, ...
//     (mod 4). Then set sel=idx, grant=1<<idx, enable=1, busy=1, cnt=0, state=ACTIVE.
//     If req==0, stay in IDLE with enable=0, grant=0.
//   Latency: req sampled high at edge N gives enable=1 from edge N to edge N+HOLD_CYCLES,
//     i.e. exactly HOLD_CYCLES cycles.
//   ACTIVE: cnt increments each cycle. When cnt==HOLD_CYCLES-1:
//     - enable<=0 and cnt<=0;
//     - go to GAP, or to IDLE if GAP_CYCLES=0.
//   GAP: enable=0; sel and grant are held. When cnt==GAP_CYCLES-1, go to IDLE.
//   Completion: on entry to IDLE, last<=served idx, grant<=0, busy<=0, done<=1 for exactly
//     one cycle. done is low in all other cycles.
//   Back-to-back: the IDLE cycle that carries done=1 also arbitrates. Pending requests
//     therefore see one IDLE cycle between services. Service period = HOLD+GAP+1 cycles.
//   Non-preemptive: req changes during ACTIVE/GAP are ignored, including deassertion of
//     the served lane. The burst always completes.
//   A lane holding req continuously is re-served only after every other requesting lane
//     (no starvation). A single requester is re-served every period.
//   sel never changes while enable=1. enable=1 implies exactly one grant bit is set.
//   cnt width = $clog2(max(HOLD_CYCLES,GAP_CYCLES,2)). No wrap is possible; the terminal
//     compare always precedes overflow.
//   Reset mid-ACTIVE: enable drops asynchronously, no done pulse is emitted, and the
//     pointer returns to last=3.
// STRUCTURE
//   Package demux_sched_pkg:
//     - N_LANES=4, SEL_W=2;
//     - state enum {S_IDLE, S_ACTIVE, S_GAP} (2-bit encoding).
//   Sub-module rr_pick4 (combinational): inputs req[3:0], last[1:0]; outputs idx[1:0], valid.
//   Top: FSM, cnt, last register, and output registers.
//   Outputs drive demux enable/sel directly, with no glue logic.
// TESTING  (HOLD=4, GAP=1 unless noted)
//   1. Reset release, req=4'b0001 held -> enable high for 4 cycles with sel=0, then
//      1 GAP cycle, then done=1; repeats with a 6-cycle period.
//   2. req=4'b1111 held -> sel sequence 0,1,2,3,0; each burst 4 cycles; one done per burst;
//      grant one-hot matches sel.
//   3. req=4'b0101 after lane 0 served -> next sel=2, then 0; lanes 1 and 3 never granted.
//   4. req pulsed one cycle at edge N -> full 4-cycle burst; done at edge N+5; then IDLE,
//      enable=0.
//   5. Reset asserted in 2nd ACTIVE cycle -> enable, grant, busy=0 immediately; no done;
//      after release with req=4'b1000, sel=3 is served first.
//   6. GAP_CYCLES=0, HOLD_CYCLES=1, req=4'b0011 -> alternating sel 0/1; enable pattern
//      1,0,1,0; done follows each service.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg
//   Shared constants and the FSM state type for the round-robin demux scheduler.
//   N_LANES : number of demux output lanes / requesters
//   SEL_W   : width of the demux select
package demux_sched_pkg;

    localparam int N_LANES = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
//   Combinational round-robin picker over four requesters.
//   Searches last+1, last+2, last+3, last (mod 4) and returns the first set bit.
//   req   : request vector, bit i = lane i
//   last  : lane served most recently
//   idx   : selected lane (0 when nothing is requested)
//   valid : high when any request bit is set
module rr_pick4
    import demux_sched_pkg::*;
(
    input  logic [N_LANES-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   idx,
    output logic               valid
);

    logic [SEL_W-1:0] w_cand;

    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        // k = N_LANES wraps back to 'last' itself, so the previously served
        // lane is considered only after every other lane.
        for (int k = 1; k <= N_LANES; k++) begin
            w_cand = last + SEL_W'(k);
            if (!valid && req[w_cand]) begin
                idx   = w_cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched
//   Round-robin scheduler driving a 1-to-4 demux. Each grant produces an enable
//   burst of HOLD_CYCLES followed by GAP_CYCLES guard cycles (sel/grant held,
//   enable low), then one IDLE cycle that pulses done and re-arbitrates.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   req    : level-sensitive request per lane (0=A 1=B 2=C 3=D)
//   sel    : demux select (registered)
//   enable : demux enable (registered)
//   grant  : one-hot lane being served in ACTIVE or GAP (registered)
//   busy   : high in ACTIVE or GAP
//   done   : one-cycle pulse on return to IDLE after a service
module demux_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic               enable,
    output logic [N_LANES-1:0] grant,
    output logic               busy,
    output logic               done
);

    localparam int CNT_HI = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W  = $clog2((CNT_HI > 2) ? CNT_HI : 2);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt,   w_cnt;
    logic [SEL_W-1:0]   r_last,  w_last;
    logic [SEL_W-1:0]   r_sel,   w_sel;
    logic               r_en,    w_en;
    logic [N_LANES-1:0] r_grant, w_grant;
    logic               r_busy,  w_busy;
    logic               r_done,  w_done;

    logic [SEL_W-1:0]   w_idx;
    logic               w_valid;

    rr_pick4 u_pick (
        .req   (req),
        .last  (r_last),
        .idx   (w_idx),
        .valid (w_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= SEL_W'(N_LANES - 1);  // lane 0 wins first after reset
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_last  <= w_last;
            r_sel   <= w_sel;
            r_en    <= w_en;
            r_grant <= w_grant;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_last  = r_last;
        w_sel   = r_sel;
        w_en    = r_en;
        w_grant = r_grant;
        w_busy  = r_busy;
        w_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_sel          = w_idx;
                    w_grant        = '0;
                    w_grant[w_idx] = 1'b1;
                    w_en           = 1'b1;
                    w_busy         = 1'b1;
                    w_cnt          = '0;
                    w_state        = S_ACTIVE;
                end else begin
                    w_en    = 1'b0;
                    w_grant = '0;
                end
            end
            S_ACTIVE: begin
                if (r_cnt == HOLD_LAST) begin
                    w_en  = 1'b0;
                    w_cnt = '0;
                    if (HAS_GAP) begin
                        w_state = S_GAP;
                    end else begin
                        w_state = S_IDLE;
                        w_last  = r_sel;
                        w_grant = '0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                w_en = 1'b0;
                if (r_cnt == GAP_LAST) begin
                    w_cnt   = '0;
                    w_state = S_IDLE;
                    w_last  = r_sel;
                    w_grant = '0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_en    = 1'b0;
                w_grant = '0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign sel    = r_sel;
    assign enable = r_en;
    assign grant  = r_grant;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb_demux_rr_sched
//   Directed bench for demux_rr_sched: one instance with HOLD=4/GAP=1 and one
//   with HOLD=1/GAP=0. Outputs are sampled on the falling clock edge.
module tb_demux_rr_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0;
    logic [1:0] sel;
    logic       enable;
    logic [3:0] grant;
    logic       busy;
    logic       done;

    logic [3:0] req1 = 4'b0;
    logic [1:0] sel1;
    logic       enable1;
    logic [3:0] grant1;
    logic       busy1;
    logic       done1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux_rr_sched #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .sel    (sel),
        .enable (enable),
        .grant  (grant),
        .busy   (busy),
        .done   (done)
    );

    demux_rr_sched #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .req    (req1),
        .sel    (sel1),
        .enable (enable1),
        .grant  (grant1),
        .busy   (busy1),
        .done   (done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full service on the HOLD=4/GAP=1 instance: 4 enable cycles, 1 gap,
    // 1 idle cycle carrying done. Optionally drops req after the first cycle.
    task automatic svc(input logic [1:0] lane, input bit drop);
        logic [3:0] g;
        g = 4'b0001 << lane;
        for (int ph = 0; ph < 6; ph++) begin
            @(negedge clk);
            chk($sformatf("en l%0d p%0d", lane, ph), enable, (ph < 4));
            chk($sformatf("busy l%0d p%0d", lane, ph), busy, (ph < 5));
            chk($sformatf("done l%0d p%0d", lane, ph), done, (ph == 5));
            chk($sformatf("grant l%0d p%0d", lane, ph), grant, (ph < 5) ? g : 4'b0);
            if (ph < 5) chk($sformatf("sel l%0d p%0d", lane, ph), sel, lane);
            if (drop && ph == 0) req = 4'b0;
        end
    endtask

    // One service on the HOLD=1/GAP=0 instance: 1 enable cycle, 1 idle/done cycle.
    task automatic svc1(input logic [1:0] lane);
        logic [3:0] g;
        g = 4'b0001 << lane;
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            chk($sformatf("en1 l%0d p%0d", lane, ph), enable1, (ph == 0));
            chk($sformatf("busy1 l%0d p%0d", lane, ph), busy1, (ph == 0));
            chk($sformatf("done1 l%0d p%0d", lane, ph), done1, (ph == 1));
            chk($sformatf("grant1 l%0d p%0d", lane, ph), grant1, (ph == 0) ? g : 4'b0);
            if (ph == 0) chk($sformatf("sel1 l%0d", lane), sel1, lane);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0;
        req1  = 4'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst en", enable, 1'b0);
        chk("rst sel", sel, 2'd0);
        chk("rst grant", grant, 4'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);

        // 1: single requester, 6-cycle period
        reset = 1'b0;
        req   = 4'b0001;
        svc(2'd0, 1'b0);
        svc(2'd0, 1'b0);

        // 2: all requesting, rotation 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        svc(2'd0, 1'b0);
        svc(2'd1, 1'b0);
        svc(2'd2, 1'b0);
        svc(2'd3, 1'b0);
        svc(2'd0, 1'b0);

        // 3: lane 0 served, then 0101 alternates 2,0,2
        do_reset();
        req = 4'b0001;
        svc(2'd0, 1'b0);
        req = 4'b0101;
        svc(2'd2, 1'b0);
        svc(2'd0, 1'b0);
        svc(2'd2, 1'b0);

        // 4: one-cycle request still gets a full burst, then stays idle
        do_reset();
        req = 4'b0100;
        svc(2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle en %0d", i), enable, 1'b0);
            chk($sformatf("idle busy %0d", i), busy, 1'b0);
            chk($sformatf("idle done %0d", i), done, 1'b0);
        end

        // 5: reset in the second ACTIVE cycle
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        chk("r5 en c1", enable, 1'b1);
        @(negedge clk);
        chk("r5 en c2", enable, 1'b1);
        reset = 1'b1;
        #1;
        chk("r5 async en", enable, 1'b0);
        chk("r5 async grant", grant, 4'b0);
        chk("r5 async busy", busy, 1'b0);
        chk("r5 async done", done, 1'b0);
        req = 4'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("r5 hold done %0d", i), done, 1'b0);
            chk($sformatf("r5 hold en %0d", i), enable, 1'b0);
        end
        reset = 1'b0;
        req   = 4'b1000;
        svc(2'd3, 1'b0);

        // 6: HOLD=1, GAP=0 instance alternates 0/1
        do_reset();
        req1 = 4'b0011;
        svc1(2'd0);
        svc1(2'd1);
        svc1(2'd0);
        svc1(2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
